// File: rtl/sfft_stream_decoder_if.sv
// Handshake and result bus between the stochastic FFT array outputs and the decoder.
// The master drives bitstreams and control; the slave (decoder) returns the counts.
interface sfft_stream_decoder_if #(
    parameter int BITWIDTH  = 8,
    parameter int NUMINPUTS = 2
);
    logic                                 iStart;
    logic                                 iEn;
    logic [NUMINPUTS-1:0]                 iReal;
    logic [NUMINPUTS-1:0]                 iImg;
    logic                                 iReady;
    logic                                 oBusy;
    logic                                 oValid;
    logic [NUMINPUTS*(BITWIDTH+1)-1:0]    oReal;
    logic [NUMINPUTS*(BITWIDTH+1)-1:0]    oImg;

    modport master (
        output iStart, iEn, iReal, iImg, iReady,
        input  oBusy, oValid, oReal, oImg
    );

    modport slave (
        input  iStart, iEn, iReal, iImg, iReady,
        output oBusy, oValid, oReal, oImg
    );
endinterface

// File: rtl/sfft_stream_decoder.sv
// Counts the 1s on each real/imaginary result lane over a 2^BITWIDTH-sample window
// and presents the per-lane counts over a valid/ready handshake.
module sfft_stream_decoder #(
    parameter int BITWIDTH  = 8,
    parameter int NUMINPUTS = 2
) (
    input  logic                  iClk,
    input  logic                  iRst,
    sfft_stream_decoder_if.slave  bus
);
    localparam int CW = BITWIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_HOLD} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [BITWIDTH-1:0]        r_win;
    logic [CW-1:0]              r_cnt_re [NUMINPUTS];
    logic [CW-1:0]              r_cnt_im [NUMINPUTS];
    logic [CW-1:0]              w_sum_re [NUMINPUTS];
    logic [CW-1:0]              w_sum_im [NUMINPUTS];
    logic [NUMINPUTS*CW-1:0]    r_out_re;
    logic [NUMINPUTS*CW-1:0]    r_out_im;
    logic                       w_sample;
    logic                       w_last;
    logic                       w_clear;
    logic                       w_busy;
    logic                       w_valid;

    assign w_sample = (r_state == S_COUNT) && bus.iEn;
    assign w_last   = w_sample && (&r_win);
    // A start is honoured from IDLE, or from HOLD only together with the handshake.
    assign w_clear  = bus.iStart &&
                      ((r_state == S_IDLE) || ((r_state == S_HOLD) && bus.iReady));

    always_comb begin
        for (int k = 0; k < NUMINPUTS; k++) begin
            w_sum_re[k] = r_cnt_re[k] + CW'(bus.iReal[k]);
            w_sum_im[k] = r_cnt_im[k] + CW'(bus.iImg[k]);
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.iStart) w_next = S_COUNT;
            S_COUNT: if (w_last) w_next = S_HOLD;
            S_HOLD:  if (bus.iReady) w_next = bus.iStart ? S_COUNT : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            S_COUNT: w_busy  = 1'b1;
            S_HOLD:  w_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_win <= '0;
            for (int k = 0; k < NUMINPUTS; k++) begin
                r_cnt_re[k] <= '0;
                r_cnt_im[k] <= '0;
            end
        end else if (w_clear) begin
            r_win <= '0;
            for (int k = 0; k < NUMINPUTS; k++) begin
                r_cnt_re[k] <= '0;
                r_cnt_im[k] <= '0;
            end
        end else if (w_sample) begin
            r_win <= r_win + 1'b1;
            for (int k = 0; k < NUMINPUTS; k++) begin
                r_cnt_re[k] <= w_sum_re[k];
                r_cnt_im[k] <= w_sum_im[k];
            end
        end
    end

    // The last sample is folded in on the fly so the result is ready the same edge.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_out_re <= '0;
            r_out_im <= '0;
        end else if (w_last) begin
            for (int k = 0; k < NUMINPUTS; k++) begin
                r_out_re[k*CW +: CW] <= w_sum_re[k];
                r_out_im[k*CW +: CW] <= w_sum_im[k];
            end
        end
    end

    assign bus.oBusy  = w_busy;
    assign bus.oValid = w_valid;
    assign bus.oReal  = r_out_re;
    assign bus.oImg   = r_out_im;
endmodule

// File: tb/tb_sfft_stream_decoder.sv
// Directed and randomized bench for sfft_stream_decoder against a sample-summing model.
module tb_sfft_stream_decoder;
    localparam int BW  = 8;
    localparam int NI  = 2;
    localparam int CW  = BW + 1;
    localparam int WIN = 1 << BW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sfft_stream_decoder_if #(.BITWIDTH(BW), .NUMINPUTS(NI)) bus();
    sfft_stream_decoder #(.BITWIDTH(BW), .NUMINPUTS(NI)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference: a window is a list of accepted samples; the result is their per-lane sum.
    bit m_win = 0;
    bit m_res = 0;
    int m_n   = 0;
    int acc_re [NI];
    int acc_im [NI];
    int res_re [NI];
    int res_im [NI];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NI*CW-1:0] pack(input int v [NI]);
        logic [NI*CW-1:0] r;
        r = '0;
        for (int k = 0; k < NI; k++) r[k*CW +: CW] = CW'(v[k]);
        return r;
    endfunction

    task automatic model_clear_all();
        m_win = 0; m_res = 0; m_n = 0;
        for (int k = 0; k < NI; k++) begin
            acc_re[k] = 0; acc_im[k] = 0; res_re[k] = 0; res_im[k] = 0;
        end
    endtask

    task automatic model_start();
        m_win = 1; m_n = 0;
        for (int k = 0; k < NI; k++) begin acc_re[k] = 0; acc_im[k] = 0; end
    endtask

    task automatic tick(input bit st, input bit en, input logic [NI-1:0] re,
                        input logic [NI-1:0] im, input bit rdy);
        bus.iStart = st; bus.iEn = en; bus.iReal = re; bus.iImg = im; bus.iReady = rdy;
        @(posedge clk);
        cyc++;
        if (rst) begin
            model_clear_all();
        end else if (m_win) begin
            if (en) begin
                for (int k = 0; k < NI; k++) begin
                    acc_re[k] += int'(re[k]);
                    acc_im[k] += int'(im[k]);
                end
                m_n++;
                if (m_n == WIN) begin
                    res_re = acc_re; res_im = acc_im;
                    m_win = 0; m_res = 1;
                end
            end
        end else if (m_res) begin
            if (rdy) begin
                m_res = 0;
                if (st) model_start();
            end
        end else if (st) begin
            model_start();
        end
        #1;
        check("busy", bus.oBusy, m_win);
        check("valid", bus.oValid, m_res);
        check("oReal", bus.oReal, pack(res_re));
        check("oImg", bus.oImg, pack(res_im));
    endtask

    task automatic gen(input int pat, input int j, output logic [NI-1:0] re, output logic [NI-1:0] im);
        re = '0; im = '0;
        case (pat)
            0: re[0] = 1'b1;
            1: begin re[0] = (j % 2 == 0); im[1] = (j % 4 == 0); end
            2: begin re = NI'($urandom); im = NI'($urandom); end
            default: ;
        endcase
    endtask

    task automatic window(input int pat, input int st_at, input int st_len, input bit rnd_en,
                          input bit spur, input bit rdy0, output int lat);
        int s, j, g, nst;
        logic [NI-1:0] re, im;
        bit en;
        tick(1'b1, 1'b0, '0, '0, rdy0);
        s = cyc; j = 0; g = 0; nst = 0;
        while (bus.oValid !== 1'b1 && g < 4 * WIN) begin
            en = !(g >= st_at && g < st_at + st_len);
            if (rnd_en) en = ($urandom_range(0, 3) != 0);
            if (en) gen(pat, j, re, im);
            else begin re = '1; im = '1; end
            tick(spur && (g == 50), en, re, im, 1'b0);
            if (en) j++; else nst++;
            g++;
        end
        lat = cyc - s;
        check("latency", lat, WIN + nst);
    endtask

    initial begin
        int lat;
        logic [NI*CW-1:0] snap_re, snap_im;
        logic [NI-1:0] re, im;
        model_clear_all();
        bus.iStart = 0; bus.iEn = 0; bus.iReal = '0; bus.iImg = '0; bus.iReady = 0;

        #2 rst = 1'b1;
        #1;
        check("rst_busy", bus.oBusy, 1'b0);
        check("rst_valid", bus.oValid, 1'b0);
        check("rst_oReal", bus.oReal, '0);
        tick(0, 0, '0, '0, 0);
        tick(1, 1, '1, '1, 1);
        rst = 1'b0;
        tick(0, 1, '1, '1, 0);

        // All-ones real lane 0
        window(0, 1 << 30, 0, 0, 0, 0, lat);
        check("t1_lat", lat, 256);
        check("t1_oReal", bus.oReal, {9'd0, 9'h100});
        check("t1_oImg", bus.oImg, {9'd0, 9'd0});
        tick(0, 0, '0, '0, 1);

        // Mixed densities
        window(1, 1 << 30, 0, 0, 0, 0, lat);
        check("t2_oReal", bus.oReal, {9'd0, 9'd128});
        check("t2_oImg", bus.oImg, {9'd64, 9'd0});
        tick(0, 0, '0, '0, 1);

        // Enable stall of 10 cycles mid-window
        window(0, 100, 10, 0, 0, 0, lat);
        check("t3_lat", lat, 266);
        check("t3_oReal", bus.oReal, {9'd0, 9'h100});
        tick(0, 0, '0, '0, 1);

        // Backpressure then back-to-back start
        window(2, 1 << 30, 0, 0, 0, 0, lat);
        snap_re = bus.oReal; snap_im = bus.oImg;
        for (int i = 0; i < 20; i++) tick(1'($urandom), 1'($urandom), NI'($urandom), NI'($urandom), 0);
        check("t4_hold_valid", bus.oValid, 1'b1);
        check("t4_hold_oReal", bus.oReal, snap_re);
        check("t4_hold_oImg", bus.oImg, snap_im);
        window(2, 1 << 30, 0, 1, 0, 1, lat);
        tick(0, 0, '0, '0, 1);
        check("t4_idle_valid", bus.oValid, 1'b0);

        // Reset mid-window
        tick(1, 0, '0, '0, 0);
        for (int i = 0; i < 100; i++) begin
            gen(2, i, re, im);
            tick(0, 1, re, im, 0);
        end
        rst = 1'b1;
        #1;
        check("t5_busy", bus.oBusy, 1'b0);
        check("t5_valid", bus.oValid, 1'b0);
        check("t5_oReal", bus.oReal, '0);
        check("t5_oImg", bus.oImg, '0);
        model_clear_all();
        tick(0, 1, '1, '1, 0);
        rst = 1'b0;
        tick(0, 1, '1, '1, 0);
        window(3, 1 << 30, 0, 0, 0, 0, lat);
        check("t5_lat", lat, 256);
        check("t5_res", {bus.oValid, bus.oReal, bus.oImg}, {1'b1, 36'd0});
        tick(0, 0, '0, '0, 1);

        // Ignored starts in COUNT and in HOLD
        window(2, 1 << 30, 0, 0, 1, 0, lat);
        check("t6_lat", lat, 256);
        for (int i = 0; i < 5; i++) tick(1, 1, '1, '1, 0);
        tick(0, 0, '0, '0, 1);
        for (int i = 0; i < 5; i++) tick(0, 1, '1, '1, 0);
        check("t6_no_extra", {bus.oBusy, bus.oValid}, 2'b00);

        // Random windows with random enables
        for (int w = 0; w < 3; w++) begin
            window(2, 1 << 30, 0, 1, 0, 0, lat);
            tick(0, 0, '0, '0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
